i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/audio_pkg.sv | 17 +
 rtl/i2s_tx_if.sv | 12 +
 rtl/audio_sat.sv | 35 +++
 rtl/i2s_tx.sv | 155 +++++++++++++++
 tb/tb_i2s_tx.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: constants and types shared by the audio output stages.
// Sample width, I2S slot geometry, clamp limits and I2S FSM encoding.
package audio_pkg;

   localparam int DATA_W = 24;
   localparam int SLOT_W = 32;

   localparam logic [DATA_W-1:0] SAT_MAX = 24'h7FFFFF;
   localparam logic [DATA_W-1:0] SAT_MIN = 24'h800000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } i2s_state_t;

endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: valid/ready sample stream into the I2S transmitter.
// The producer drives data/valid, the transmitter drives ready.
interface i2s_tx_if;

   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/audio_sat.sv
// audio_sat: clamp a signed 32-bit sample to a signed DATA_W-bit range.
// Purely combinational; clip_o flags that the limit was applied.
module audio_sat #(
   parameter int DATA_W = audio_pkg::DATA_W
) (
   input  logic signed [31:0]       in_i,
   output logic        [DATA_W-1:0] out_o,
   output logic                     clip_o
);

   localparam logic [DATA_W-1:0] HI_C =
      (DATA_W == audio_pkg::DATA_W) ? audio_pkg::SAT_MAX
                                    : {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] LO_C =
      (DATA_W == audio_pkg::DATA_W) ? audio_pkg::SAT_MIN
                                    : {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [31:0] HI_S =
      {{(32-DATA_W){HI_C[DATA_W-1]}}, HI_C};
   localparam logic signed [31:0] LO_S =
      {{(32-DATA_W){LO_C[DATA_W-1]}}, LO_C};

   // Pass the low bits through unless the value is outside the range.
   always_comb begin
      out_o  = in_i[DATA_W-1:0];
      clip_o = 1'b0;
      if (in_i > HI_S) begin
         out_o  = HI_C;
         clip_o = 1'b1;
      end else if (in_i < LO_S) begin
         out_o  = LO_C;
         clip_o = 1'b1;
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: mono I2S transmitter with a one-sample holding register.
// bclk is divided from clk; sdata/lrclk move only on bclk falling edges.
module i2s_tx
   import audio_pkg::*;
#(
   parameter int BCLK_DIV = 2,
   parameter int DATA_W   = audio_pkg::DATA_W,
   parameter int SLOT_W   = audio_pkg::SLOT_W
) (
   input  logic    clk,
   input  logic    rst,
   i2s_tx_if.slave s_if,
   output logic    bclk,
   output logic    lrclk,
   output logic    sdata,
   output logic    sat,
   output logic    underrun
);

   localparam int DVW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int PW  = $clog2(2 * SLOT_W);
   localparam int IW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [DVW-1:0] DIV_LAST = DVW'(BCLK_DIV - 1);
   localparam logic [PW-1:0]  P_LAST   = PW'(2 * SLOT_W - 1);
   localparam logic [PW-1:0]  P_SLOT   = PW'(SLOT_W);
   localparam logic [PW-1:0]  P_LR_LO  = PW'(SLOT_W - 1);
   localparam logic [PW-1:0]  K_MAX    = PW'(DATA_W);

   logic [DVW-1:0]    div_q, div_d;
   logic              bclk_q, bclk_d;
   logic [PW-1:0]     p_q, p_d;
   logic              lrclk_q, lrclk_d;
   logic              sdata_q, sdata_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hv_q, hv_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic              sat_q, sat_d;
   logic              und_q, und_d;
   i2s_state_t        st_q, st_d;

   logic              tick, fall, load, xfer, clip;
   logic [PW-1:0]     p_nx, k_nx;
   logic [IW-1:0]     bit_sel;
   logic [DATA_W-1:0] clamp;

   audio_sat #(.DATA_W(DATA_W)) u_sat (
      .in_i   (s_if.s_data),
      .out_o  (clamp),
      .clip_o (clip)
   );

   assign tick    = (div_q == DIV_LAST);
   assign fall    = tick && bclk_q;
   assign xfer    = s_if.s_valid && !hv_q;
   assign p_nx    = (p_q == P_LAST) ? '0 : p_q + 1'b1;
   assign k_nx    = (p_nx >= P_SLOT) ? p_nx - P_SLOT : p_nx;
   assign bit_sel = IW'(DATA_W - int'(k_nx));

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) st_q <= ST_IDLE;
      else     st_q <= st_d;
   end

   // FSM next state: slot boundaries fall on bclk falling edges.
   always_comb begin
      st_d = st_q;
      if (fall) begin
         case (st_q)
            ST_IDLE:  st_d = ST_LEFT;
            ST_LEFT:  if (p_nx == P_SLOT) st_d = ST_RIGHT;
            ST_RIGHT: if (p_nx == '0)     st_d = ST_LEFT;
            default:  st_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs: a frame load happens on the fall that opens a left slot.
   always_comb begin
      load = 1'b0;
      case (st_q)
         ST_IDLE:  load = fall;
         ST_RIGHT: load = fall && (p_nx == '0);
         default:  load = 1'b0;
      endcase
   end

   // Next values for divider, serializer, holding register and pulses.
   always_comb begin
      div_d   = tick ? '0 : div_q + 1'b1;
      bclk_d  = tick ? ~bclk_q : bclk_q;
      p_d     = p_q;
      lrclk_d = lrclk_q;
      sdata_d = sdata_q;
      hold_d  = hold_q;
      hv_d    = hv_q;
      tx_d    = tx_q;
      sat_d   = xfer && clip;
      und_d   = 1'b0;
      if (fall) begin
         p_d     = p_nx;
         lrclk_d = (p_nx >= P_LR_LO) && (p_nx != P_LAST);
         sdata_d = (k_nx != '0) && (k_nx <= K_MAX) && tx_q[bit_sel];
      end
      if (xfer) begin
         hold_d = clamp;
         hv_d   = 1'b1;
      end
      if (load) begin
         if (hv_q) begin
            tx_d = hold_q;
            hv_d = 1'b0;
         end else begin
            tx_d  = '0;
            und_d = 1'b1;
         end
      end
   end

   // Datapath registers; reset aborts any frame and drops the held sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q   <= '0;
         bclk_q  <= 1'b0;
         p_q     <= P_LAST;
         lrclk_q <= 1'b1;
         sdata_q <= 1'b0;
         hold_q  <= '0;
         hv_q    <= 1'b0;
         tx_q    <= '0;
         sat_q   <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         div_q   <= div_d;
         bclk_q  <= bclk_d;
         p_q     <= p_d;
         lrclk_q <= lrclk_d;
         sdata_q <= sdata_d;
         hold_q  <= hold_d;
         hv_q    <= hv_d;
         tx_q    <= tx_d;
         sat_q   <= sat_d;
         und_q   <= und_d;
      end
   end

   assign s_if.s_ready = !hv_q;
   assign bclk         = bclk_q;
   assign lrclk        = lrclk_q;
   assign sdata        = sdata_q;
   assign sat          = sat_q;
   assign underrun     = und_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx with BCLK_DIV=2 (256 clk/frame).
// Stimulus queues expected frames and sat flags; a monitor decodes I2S.
module tb_i2s_tx;

   logic clk = 1'b0;
   logic rst;
   logic bclk, lrclk, sdata, sat, underrun;

   i2s_tx_if sif ();

   i2s_tx #(
      .BCLK_DIV (2),
      .DATA_W   (24),
      .SLOT_W   (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_if     (sif),
      .bclk     (bclk),
      .lrclk    (lrclk),
      .sdata    (sdata),
      .sat      (sat),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] word;
      logic        und;
   } frame_t;

   frame_t fq[$];
   bit     satq[$];
   int     n_cmp = 0;
   int     n_err = 0;
   int     frames_seen = 0;
   int     mp = 63;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: expected event missing (t=%0t)", nm, $time);
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   endtask

   task automatic push_frame(input logic [23:0] w, input logic u);
      frame_t f;
      f.word = w;
      f.und  = u;
      fq.push_back(f);
   endtask

   task automatic wait_frames(input int target);
      int t = 0;
      while (frames_seen < target) begin
         @(negedge clk);
         t++;
         if (t > 2000) begin
            fail_now("frame_timeout");
            summary();
         end
      end
   endtask

   task automatic send(input logic [31:0] v, input bit sat_exp);
      int t = 0;
      satq.push_back(sat_exp);
      sif.s_data  = v;
      sif.s_valid = 1'b1;
      do begin
         @(negedge clk);
         t++;
         if (t > 1000) begin
            fail_now("s_ready_timeout");
            summary();
         end
      end while (!sif.s_ready);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      sif.s_valid = 1'b0;
      sif.s_data  = '0;
   endtask

   frame_t      cur;
   bit          cur_v = 0;
   logic [23:0] word = '0;
   int          pad_err = 0, lr_err = 0, chg_err = 0;
   logic        pb = 1'b0, psd = 1'b0, plr = 1'b1;
   bit          pend = 0, pend_exp = 0;

   // Monitor: decodes the I2S stream and checks sat/underrun pulses.
   always @(negedge clk) begin : mon
      bit fs, rs;
      int k;
      if (rst) begin
         mp = 63; cur_v = 0; pend = 0; word = '0;
         pb = 1'b0; psd = 1'b0; plr = 1'b1;
         pad_err = 0; lr_err = 0; chg_err = 0;
      end else begin
         fs = pb && !bclk;
         rs = !pb && bclk;
         if (pend) begin
            chk("sat_pulse", sat, pend_exp);
            pend = 0;
         end else if (sat) begin
            chk("sat_spurious", sat, 0);
         end
         if (sif.s_valid && sif.s_ready) begin
            if (satq.size() == 0) fail_now("sat_queue_empty");
            else begin
               pend_exp = satq.pop_front();
               pend = 1;
            end
         end
         if (!fs && (sdata !== psd || lrclk !== plr)) chg_err++;
         if (underrun && !(fs && mp == 63))
            chk("underrun_spurious", underrun, 0);
         if (fs) begin
            mp = (mp + 1) % 64;
            if (mp == 0) begin
               if (cur_v) begin
                  chk("pad_bits", pad_err, 0);
                  chk("lrclk", lr_err, 0);
                  chk("edge_only", chg_err, 0);
               end
               pad_err = 0; lr_err = 0; chg_err = 0;
               if (fq.size() == 0) begin
                  fail_now("frame_queue_empty");
                  cur_v = 0;
               end else begin
                  cur = fq.pop_front();
                  cur_v = 1;
                  chk("underrun", underrun, cur.und);
               end
               frames_seen++;
            end
         end
         if (rs && cur_v) begin
            k = mp % 32;
            if (lrclk !== ((mp >= 31) && (mp <= 62))) lr_err++;
            if (k >= 1 && k <= 24) begin
               word = {word[22:0], sdata};
               if (k == 24)
                  chk(mp < 32 ? "left_word" : "right_word", word, cur.word);
            end else if (sdata !== 1'b0) begin
               pad_err++;
            end
         end
         pb = bclk; psd = sdata; plr = lrclk;
      end
   end

   initial begin
      #200000;
      fail_now("watchdog");
      summary();
   end

   // Stimulus: directed samples with their expected frames queued ahead.
   initial begin
      logic [3:0] lat_exp;
      int t;
      lat_exp = 4'b0110;
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_bclk", bclk, 0);
      chk("rst_lrclk", lrclk, 1);
      chk("rst_sdata", sdata, 0);
      chk("rst_s_ready", sif.s_ready, 1);
      chk("rst_sat", sat, 0);
      chk("rst_underrun", underrun, 0);
      push_frame(24'h0, 1'b1);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("lat_bclk", bclk, lat_exp[i]);
      end
      chk("lat_first_underrun", underrun, 1);

      wait_frames(1);
      push_frame(24'h100000, 1'b0);
      @(posedge clk); #1;
      send(32'h0010_0000, 1'b0);
      idle();

      wait_frames(2);
      push_frame(24'h7FFFFF, 1'b0);
      @(posedge clk); #1;
      send(32'h0080_0000, 1'b1);
      idle();

      wait_frames(3);
      push_frame(24'h800000, 1'b0);
      @(posedge clk); #1;
      send(32'hFF7F_FFFF, 1'b1);
      idle();

      wait_frames(4);
      push_frame(24'h0, 1'b1);

      wait_frames(5);
      push_frame(24'd1, 1'b0);
      push_frame(24'd2, 1'b0);
      push_frame(24'd3, 1'b0);
      push_frame(24'h0, 1'b1);
      @(posedge clk); #1;
      send(32'd1, 1'b0);
      @(negedge clk);
      chk("s_ready_after_accept", sif.s_ready, 0);
      @(posedge clk); #1;
      send(32'd2, 1'b0);
      send(32'd3, 1'b0);
      idle();

      wait_frames(9);
      push_frame(24'h0, 1'b1);

      wait_frames(10);
      @(posedge clk); #1;
      send(32'h0000_0555, 1'b0);
      idle();
      t = 0;
      while (mp != 40) begin
         @(negedge clk);
         t++;
         if (t > 1000) begin
            fail_now("p40_timeout");
            summary();
         end
      end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_bclk", bclk, 0);
      chk("mid_rst_lrclk", lrclk, 1);
      chk("mid_rst_sdata", sdata, 0);
      chk("mid_rst_s_ready", sif.s_ready, 1);
      chk("mid_rst_sat", sat, 0);
      chk("mid_rst_underrun", underrun, 0);
      push_frame(24'h0, 1'b1);

      wait_frames(11);
      push_frame(24'h800000, 1'b0);
      @(posedge clk); #1;
      send(32'hFF80_0000, 1'b0);
      idle();

      wait_frames(12);
      push_frame(24'h7FFFFF, 1'b0);
      push_frame(24'h0, 1'b1);
      @(posedge clk); #1;
      send(32'h007F_FFFF, 1'b0);
      idle();

      wait_frames(14);
      repeat (4) @(negedge clk);
      chk("frame_queue_drained", fq.size(), 0);
      chk("sat_queue_drained", satq.size(), 0);
      summary();
   end

endmodule
